instr_decode: RTL

INSTR_DECODE -- requirements
Module: instr_decode

---
 rtl/instr_decode.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/instr_decode.sv
// Multi-cycle instruction fetch/decode controller: fetches one 32-bit word per
// instruction, decodes register addresses, immediate and ALU op, and pulses wr_en in WB.
module instr_decode #(
  parameter int unsigned PC_WIDTH     = 8,
  parameter int unsigned IMEM_LAT_MAX = 15
) (
  input  logic                clk,
  input  logic                RESET,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_data,
  output logic [2:0]          INaddr,
  output logic [2:0]          OUT1addr,
  output logic [2:0]          OUT2addr,
  output logic [7:0]          IMM,
  output logic                imm_sel,
  output logic [2:0]          alu_op,
  output logic                wr_en,
  output logic                illegal,
  output logic                fault
);

  localparam int unsigned WW = (IMEM_LAT_MAX > 1) ? $clog2(IMEM_LAT_MAX) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(IMEM_LAT_MAX - 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    STALL  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic                req_q, req_d;
  logic                fault_q, fault_d;
  logic [2:0]          ina_q, ina_d;
  logic [2:0]          out1_q, out1_d;
  logic [2:0]          out2_q, out2_d;
  logic [7:0]          imm_q, imm_d;
  logic                sel_q, sel_d;
  logic [2:0]          op_q, op_d;
  logic                ill_q, ill_d;

  // Only the low three bits of the dest/src1 fields address registers.
  logic unused_ir;
  assign unused_ir = ^{ir_q[23:19], ir_q[15:11]};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    ina_d   = ina_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    imm_d   = imm_q;
    sel_d   = sel_q;
    op_d    = op_q;
    ill_d   = ill_q;

    unique case (state_q)
      FETCH: begin
        // req_q is low only in the first cycle after reset; ack is ignored then.
        if (req_q) begin
          if (imem_ack) begin
            ir_d    = imem_data;
            wait_d  = '0;
            state_d = DECODE;
          end else if (wait_q == WAIT_LAST) begin
            fault_d = 1'b1;
            state_d = STALL;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      DECODE: begin
        ina_d  = ir_q[18:16];
        out1_d = ir_q[10:8];
        out2_d = ir_q[2:0];
        imm_d  = ir_q[7:0];
        sel_d  = 1'b0;
        op_d   = 3'b000;
        ill_d  = 1'b0;
        case (ir_q[31:24])
          8'h00:   sel_d = 1'b1;
          8'h01:   op_d  = 3'b000;
          8'h02:   op_d  = 3'b001;
          8'h03:   op_d  = 3'b010;
          8'h04:   op_d  = 3'b011;
          8'h05:   op_d  = 3'b100;
          default: ill_d = 1'b1;
        endcase
        state_d = EXEC;
      end
      EXEC: state_d = WB;
      WB: begin
        pc_d    = pc_q + 1'b1;
        state_d = FETCH;
      end
      STALL: state_d = STALL;
      default: state_d = FETCH;
    endcase

    req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      wait_q  <= '0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
      ina_q   <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      imm_q   <= '0;
      sel_q   <= 1'b0;
      op_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      fault_q <= fault_d;
      ina_q   <= ina_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      imm_q   <= imm_d;
      sel_q   <= sel_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign INaddr    = ina_q;
  assign OUT1addr  = out1_q;
  assign OUT2addr  = out2_q;
  assign IMM       = imm_q;
  assign imm_sel   = sel_q;
  assign alu_op    = op_q;
  assign fault     = fault_q;
  assign wr_en     = (state_q == WB) & ~ill_q;
  assign illegal   = (state_q == WB) & ill_q;

endmodule
